seq_scan_ctrl: RTL and testbench

Serial pattern-scan controller that sequences a bit-serial pattern detector over parallel input words. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it MSB-first through a programmable pattern detector, one bit per clock. It supports patterns of up to PAT_W bits, in overlapping or non-overlapping mode. For each word it returns the number of matches over a second valid/ready handshake. It sits between a word-oriented producer and the serial detection datapath, and supplies both the per-bit sequencing and the pattern configuration.

---
 rtl/seq_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Serial pattern-scan controller: accepts a word, shifts it MSB-first through a
// programmable bit-serial pattern detector, and returns the per-word match count.
module seq_scan_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned LEN_W  = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    output logic              det_o,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;

    logic [DATA_W-1:0]  r_word;
    logic [PAT_W-1:0]   r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [PAT_W-1:0]   r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_det_o;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;

    logic [LEN_W-1:0]   w_len_eff;
    logic               w_bit;
    logic [PAT_W-1:0]   w_hist_new;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [PAT_W-1:0]   w_mask;
    logic               w_match;

    // State register; status outputs are registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == S_IDLE);
            r_busy      <= (w_state_next != S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_idx == IDX_W'(DATA_W - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Detector datapath: next history, saturating fill and masked compare
    always_comb begin
        w_len_eff  = ((cfg_len == '0) || (int'(cfg_len) > int'(PAT_W)))
                     ? LEN_W'(PAT_W) : cfg_len;
        w_bit      = r_word[DATA_W-1];
        w_hist_new = {r_hist[PAT_W-2:0], w_bit};
        w_fill_inc = (int'(r_fill) >= int'(PAT_W)) ? LEN_W'(PAT_W) : r_fill + LEN_W'(1);
        w_mask     = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_match    = (w_fill_inc >= r_len) &&
                     (((w_hist_new ^ r_pattern) & w_mask) == '0);
    end

    // Word capture and per-bit sequencing
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_det_o   <= 1'b0;
        end else begin
            r_det_o <= 1'b0;
            if (w_accept) begin
                r_word    <= in_data;
                r_pattern <= cfg_pattern;
                r_len     <= w_len_eff;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
                r_idx     <= '0;
                r_count   <= '0;
            end else if (r_state == S_SHIFT) begin
                r_word  <= {r_word[DATA_W-2:0], 1'b0};
                r_hist  <= w_hist_new;
                // Non-overlapping mode retires the bits that formed a match
                r_fill  <= (w_match && !r_overlap) ? '0 : w_fill_inc;
                r_idx   <= r_idx + IDX_W'(1);
                r_det_o <= w_match;
                r_count <= r_count + CNT_W'(w_match);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign det_o     = r_det_o;
    assign out_count = r_count;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: hand-computed per-bit detect pulses and counts.
module tb_seq_scan_ctrl;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       det_o;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;

    int n_checks;
    int n_errors;

    seq_scan_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .det_o      (det_o),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scan one word; exp_det bit k-1 is the det_o value expected after edge Ek
    task automatic run_word(input logic [7:0] word, input logic [3:0] pat,
                            input logic [2:0] len, input logic ov,
                            input logic [7:0] exp_det, input logic [3:0] exp_cnt,
                            input bit scramble, input int hold);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_data     = word;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_in_ready", 32'(in_ready), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        if (scramble) begin
            cfg_pattern = 4'b0000;
            cfg_len     = 3'd1;
            cfg_overlap = ~ov;
            in_data     = ~word;
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("det_E%0d", k), 32'(det_o), 32'(exp_det[k-1]));
            if (k < 8) check($sformatf("no_valid_E%0d", k), 32'(out_valid), 32'd0);
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_count", 32'(out_count), 32'(exp_cnt));
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            for (int h = 0; h < hold; h++) begin
                tick();
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_count", 32'(out_count), 32'(exp_cnt));
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_det", 32'(det_o), 32'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("taken_valid", 32'(out_valid), 32'd0);
        check("taken_in_ready", 32'(in_ready), 32'd1);
        check("taken_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'hAA;
        cfg_pattern = 4'b0101;
        cfg_len     = 3'd3;
        cfg_overlap = 1'b1;
        out_ready   = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_det", 32'(det_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // 1010_1010 / 101: overlap hits at E3,E5,E7; non-overlap at E3,E7
        run_word(8'b1010_1010, 4'b0101, 3'd3, 1'b1, 8'b0101_0100, 4'd3, 1'b0, 0);
        run_word(8'b1010_1010, 4'b0101, 3'd3, 1'b0, 8'b0100_0100, 4'd2, 1'b0, 0);
        // Single-bit pattern: every 1 matches, every 0 does not
        run_word(8'hFF, 4'b0001, 3'd1, 1'b1, 8'hFF, 4'd8, 1'b0, 0);
        run_word(8'h00, 4'b0001, 3'd1, 1'b1, 8'h00, 4'd0, 1'b0, 0);
        // len 0 acts as 4; config changes mid-scan have no effect
        run_word(8'hF0, 4'b1111, 3'd0, 1'b1, 8'b0000_1000, 4'd1, 1'b1, 0);
        // len 7 (> PAT_W) also acts as 4
        run_word(8'hF0, 4'b1111, 3'd7, 1'b1, 8'b0000_1000, 4'd1, 1'b0, 0);
        // Backpressure in DONE for 5 cycles with in_valid held high
        run_word(8'b1010_1010, 4'b0101, 3'd3, 1'b1, 8'b0101_0100, 4'd3, 1'b0, 5);
        tick();
        check("bp_no_second_accept", 32'(busy), 32'd0);

        // Reset sampled at E4 mid-scan
        in_data     = 8'b1010_1010;
        cfg_pattern = 4'b0101;
        cfg_len     = 3'd3;
        cfg_overlap = 1'b1;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_det_E3", 32'(det_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_det", 32'(det_o), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        check("midrst_stays_idle", 32'(busy), 32'd0);
        // Fresh word after reset: 0101_0000 / 101 sees only one match at E4
        run_word(8'b0101_0000, 4'b0101, 3'd3, 1'b1, 8'b0000_1000, 4'd1, 1'b0, 0);
        run_word(8'b1010_1010, 4'b0101, 3'd3, 1'b0, 8'b0100_0100, 4'd2, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
